// File: rtl/vram_fill_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : vram_fill_arbiter_if
//  Description : Bundle of the CPU write path, the fill-command handshake and
//                the VRAM port A write outputs used by vram_fill_arbiter.
//                slave  - view of the arbiter (drives status and port A)
//                master - view of the CPU / command source (drives requests)
//  Signals     : cpu_we/cpu_addr/cpu_data       CPU VRAM write request
//                cmd_valid/cmd_ready            fill-command handshake
//                cmd_row/cmd_count/cmd_char     fill-command payload
//                busy/done                      engine status
//                v_cea/v_ada/v_din              VRAM port A write (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vram_fill_arbiter_if #(
    parameter int AW = 10
);
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [4:0]    cmd_row;
    logic [4:0]    cmd_count;
    logic [7:0]    cmd_char;
    logic          busy;
    logic          done;
    logic          v_cea;
    logic [AW-1:0] v_ada;
    logic [7:0]    v_din;

    modport slave (
        input  cpu_we, cpu_addr, cpu_data,
        input  cmd_valid, cmd_row, cmd_count, cmd_char,
        output cmd_ready, busy, done,
        output v_cea, v_ada, v_din
    );

    modport master (
        output cpu_we, cpu_addr, cpu_data,
        output cmd_valid, cmd_row, cmd_count, cmd_char,
        input  cmd_ready, busy, done,
        input  v_cea, v_ada, v_din
    );
endinterface
`default_nettype wire

// File: rtl/vram_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vram_fill_arbiter
//  Description : Shares VRAM port A between CPU writes and a row-fill engine.
//                CPU writes always win; the engine writes one character per
//                free cycle until rows [cmd_row, min(cmd_row+cmd_count,ROWS))
//                are filled with cmd_char. All port A outputs are registered.
//  Ports       : clk            memory clock
//                rst            synchronous active-high reset
//                bus (slave)    CPU write inputs, fill command handshake,
//                               busy/done status, VRAM port A write outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_fill_arbiter #(
    parameter int COLS = 60,
    parameter int ROWS = 17,
    parameter int AW   = 10
) (
    input  wire logic         clk,
    input  wire logic         rst,
    vram_fill_arbiter_if.slave bus
);

    localparam int            c_CW       = $clog2(COLS);
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(COLS - 1);
    localparam logic [AW-1:0] c_COLS_AW  = AW'(COLS);
    localparam logic [5:0]    c_ROWS6    = 6'(ROWS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [4:0]      r_row;
    logic [c_CW-1:0] r_col;
    logic [AW-1:0]   r_base;
    logic [5:0]      r_end;
    logic [7:0]      r_char;
    logic            r_null;
    logic            r_cmd_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_v_cea;
    logic [AW-1:0]   r_v_ada;
    logic [7:0]      r_v_din;

    logic            w_cmd_fire;
    logic [5:0]      w_sum6;
    logic [5:0]      w_end;
    logic            w_null;
    logic [AW-1:0]   w_base0;
    logic [AW-1:0]   w_eng_addr;
    logic            w_eng_go;
    logic            w_last;
    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic [7:0]      w_data;

    assign w_cmd_fire = bus.cmd_valid & r_cmd_ready;

    // End row clamped to the screen height; 6 bits hold the worst-case sum.
    assign w_sum6 = {1'b0, bus.cmd_row} + {1'b0, bus.cmd_count};
    assign w_end  = (w_sum6 > c_ROWS6) ? c_ROWS6 : w_sum6;
    assign w_null = (bus.cmd_count == 5'd0) | ({1'b0, bus.cmd_row} >= c_ROWS6);

    // Starting row base = cmd_row * COLS, built as a sum of shifted copies of
    // cmd_row for each set bit of COLS. Only used once per command.
    always_comb begin
        w_base0 = '0;
        for (int i = 0; i < AW; i++) begin
            if (c_COLS_AW[i]) begin
                w_base0 = w_base0 + (AW'(bus.cmd_row) << i);
            end
        end
    end

    // Inside the loop the address is just base + col; base steps by COLS.
    assign w_eng_addr = r_base + AW'(r_col);
    assign w_eng_go   = (r_state == S_FILL) & ~bus.cpu_we;
    assign w_last     = (r_col == c_COL_LAST) & ({1'b0, r_row} == (r_end - 6'd1));

    // CPU has absolute priority; the engine only takes cycles the CPU leaves.
    assign w_we   = bus.cpu_we | w_eng_go;
    assign w_addr = bus.cpu_we ? bus.cpu_addr : w_eng_addr;
    assign w_data = bus.cpu_we ? bus.cpu_data : r_char;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_base      <= '0;
            r_end       <= '0;
            r_char      <= '0;
            r_null      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_v_cea     <= 1'b0;
            r_v_ada     <= '0;
            r_v_din     <= '0;
        end else begin
            r_v_cea <= w_we;
            if (w_we) begin
                r_v_ada <= w_addr;
                r_v_din <= w_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_char      <= bus.cmd_char;
                        r_row       <= bus.cmd_row;
                        r_col       <= '0;
                        r_base      <= w_base0;
                        r_end       <= w_end;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_null) begin
                            // Null command spends one extra cycle in DONE so
                            // its done pulse lands two cycles after handshake.
                            r_state <= S_DONE;
                            r_null  <= 1'b1;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end

                S_FILL: begin
                    if (w_eng_go) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_null  <= 1'b0;
                        end else if (r_col == c_COL_LAST) begin
                            r_col  <= '0;
                            r_base <= r_base + c_COLS_AW;
                            r_row  <= r_row + 5'd1;
                        end else begin
                            r_col <= r_col + c_CW'(1);
                        end
                    end
                end

                S_DONE: begin
                    if (r_null) begin
                        r_null <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_state     <= S_IDLE;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_null      <= 1'b0;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.v_cea     = r_v_cea;
    assign bus.v_ada     = r_v_ada;
    assign bus.v_din     = r_v_din;

endmodule
`default_nettype wire

// File: tb/tb_vram_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_fill_arbiter
//  Description : Self-checking bench for vram_fill_arbiter. A behavioural
//                model (queue of pending fill addresses plus a phase counter)
//                predicts every port/status output each cycle; directed and
//                randomized commands with CPU traffic are applied.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_fill_arbiter;

    localparam int COLS = 60;
    localparam int ROWS = 17;
    localparam int AW   = 10;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vram_fill_arbiter_if #(.AW(AW)) bus ();

    vram_fill_arbiter #(
        .COLS (COLS),
        .ROWS (ROWS),
        .AW   (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Model: 0 idle, 1 filling, 2 null-command wait, 3 done pulse
    int          m_phase = 0;
    int          m_q[$];
    logic [7:0]  m_char = 8'h00;
    logic        e_cea, e_ready, e_busy, e_done;
    logic [AW-1:0] e_ada;
    logic [7:0]  e_din;

    logic [7:0]  mem [0:1023];
    int          n_wr  = 0;
    int          n_cpu = 0;
    bit          pulse [0:2047];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_tick();
        int nxt;
        int r_end;
        if (rst) begin
            m_phase = 0;
            m_q.delete();
            e_cea = 1'b0;
            e_ada = '0;
            e_din = '0;
        end else begin
            nxt = m_phase;
            if (bus.cpu_we) begin
                e_cea = 1'b1;
                e_ada = bus.cpu_addr;
                e_din = bus.cpu_data;
            end else if (m_phase == 1) begin
                e_cea = 1'b1;
                e_ada = AW'(m_q.pop_front());
                e_din = m_char;
                if (m_q.size() == 0) nxt = 3;
            end else begin
                e_cea = 1'b0;
            end
            case (m_phase)
                0: if (bus.cmd_valid) begin
                    m_char = bus.cmd_char;
                    r_end  = int'(bus.cmd_row) + int'(bus.cmd_count);
                    if (r_end > ROWS) r_end = ROWS;
                    for (int r = int'(bus.cmd_row); r < r_end; r++)
                        for (int c = 0; c < COLS; c++)
                            m_q.push_back(r * COLS + c);
                    nxt = (m_q.size() == 0) ? 2 : 1;
                end
                2: nxt = 3;
                3: nxt = 0;
                default: ;
            endcase
            m_phase = nxt;
        end
        e_ready = (m_phase == 0);
        e_busy  = (m_phase != 0);
        e_done  = (m_phase == 3);
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        chk("v_cea",     32'(bus.v_cea),     32'(e_cea));
        chk("v_ada",     32'(bus.v_ada),     32'(e_ada));
        chk("v_din",     32'(bus.v_din),     32'(e_din));
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(e_ready));
        chk("busy",      32'(bus.busy),      32'(e_busy));
        chk("done",      32'(bus.done),      32'(e_done));
        if (bus.v_cea === 1'b1) begin
            mem[bus.v_ada] = bus.v_din;
            n_wr++;
            if (bus.v_ada == 10'd1021 && bus.v_din == 8'h55) n_cpu++;
        end
    endtask

    task automatic issue(input int row, input int count, input logic [7:0] ch);
        logic pre;
        bit   ok;
        ok = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_row   = 5'(row);
        bus.cmd_count = 5'(count);
        bus.cmd_char  = ch;
        for (int i = 0; i < 5000; i++) begin
            pre = bus.cmd_ready;
            step();
            if (pre === 1'b1) begin
                ok = 1;
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        if (!ok) chk("handshake_timeout", 32'(bus.cmd_ready), 32'd1);
    endtask

    // mode 0: no CPU traffic, 1: pulses from pulse[], 2: random CPU writes
    task automatic wait_done(input int mode, output int k);
        bit seen;
        seen = 0;
        k = 0;
        while (k < 3000) begin
            case (mode)
                1: bus.cpu_we = pulse[k];
                2: begin
                    bus.cpu_we   = ($urandom_range(0, 3) == 0);
                    bus.cpu_addr = AW'($urandom);
                    bus.cpu_data = 8'($urandom);
                end
                default: bus.cpu_we = 1'b0;
            endcase
            step();
            k++;
            if (bus.done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        bus.cpu_we = 1'b0;
        if (!seen) chk("done_timeout", 32'(bus.done), 32'd1);
    endtask

    function automatic int count_ne(input int lo, input int hi, input logic [7:0] v);
        int n;
        n = 0;
        for (int a = lo; a <= hi; a++) if (mem[a] !== v) n++;
        return n;
    endfunction

    initial begin
        int k, w0, d, h, np;
        logic pre;

        rst = 1'b1;
        bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
        bus.cmd_valid = 1'b0; bus.cmd_row = '0; bus.cmd_count = '0; bus.cmd_char = '0;
        for (int a = 0; a < 1024; a++) mem[a] = 8'hEE;

        step();
        step();
        rst = 1'b0;
        repeat (3) step();

        // Null command: zero count
        w0 = n_wr;
        issue(0, 0, 8'h11);
        wait_done(0, k);
        chk("null_cnt_latency", 32'(k), 32'd1);
        chk("null_cnt_writes",  32'(n_wr - w0), 32'd0);
        repeat (2) step();

        // Null command: row out of range
        w0 = n_wr;
        issue(17, 3, 8'h12);
        wait_done(0, k);
        chk("null_row_latency", 32'(k), 32'd1);
        chk("null_row_writes",  32'(n_wr - w0), 32'd0);
        repeat (2) step();

        // Full clear, no contention
        w0 = n_wr;
        issue(0, 17, 8'h20);
        wait_done(0, k);
        chk("clear_latency", 32'(k), 32'd1020);
        chk("clear_writes",  32'(n_wr - w0), 32'd1020);
        chk("clear_content", 32'(count_ne(0, 1019, 8'h20)), 32'd0);
        repeat (2) step();

        // Partial fill clamped at the bottom of the screen
        for (int a = 0; a < 1024; a++) mem[a] = 8'hEE;
        w0 = n_wr;
        issue(15, 5, 8'h41);
        wait_done(0, k);
        chk("partial_latency", 32'(k), 32'd120);
        chk("partial_writes",  32'(n_wr - w0), 32'd120);
        chk("partial_low",     32'(count_ne(0, 899, 8'hEE)), 32'd0);
        chk("partial_rows",    32'(count_ne(900, 1019, 8'h41)), 32'd0);
        chk("partial_top",     32'(count_ne(1020, 1023, 8'hEE)), 32'd0);
        repeat (2) step();

        // Full clear with 10 scattered CPU writes
        for (int i = 0; i < 2048; i++) pulse[i] = 1'b0;
        np = 0;
        while (np < 10) begin
            k = $urandom_range(5, 1000);
            if (!pulse[k]) begin
                pulse[k] = 1'b1;
                np++;
            end
        end
        bus.cpu_addr = 10'd1021;
        bus.cpu_data = 8'h55;
        n_cpu = 0;
        w0 = n_wr;
        issue(0, 17, 8'h20);
        wait_done(1, k);
        chk("contend_latency",  32'(k), 32'd1030);
        chk("contend_cpu_wr",   32'(n_cpu), 32'd10);
        chk("contend_writes",   32'(n_wr - w0), 32'd1030);
        repeat (2) step();

        // Second command held during FILL is accepted only after done
        issue(2, 1, 8'h33);
        bus.cmd_valid = 1'b1;
        bus.cmd_row   = 5'd5;
        bus.cmd_count = 5'd1;
        bus.cmd_char  = 8'h44;
        d = -1;
        h = -1;
        for (int i = 0; i < 500; i++) begin
            pre = bus.cmd_ready;
            step();
            if (bus.done === 1'b1) d = i;
            if (pre === 1'b1) begin
                h = i;
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        chk("reject_done_at", 32'(d), 32'd59);
        chk("reject_accept",  32'(h), 32'd61);
        wait_done(0, k);
        chk("reject_latency", 32'(k), 32'd60);
        chk("reject_first",   32'(count_ne(120, 179, 8'h33)), 32'd0);
        chk("reject_second",  32'(count_ne(300, 359, 8'h44)), 32'd0);
        repeat (2) step();

        // Reset in the middle of a fill
        issue(0, 17, 8'h66);
        repeat (100) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        w0 = n_wr;
        repeat (30) step();
        chk("reset_no_writes", 32'(n_wr - w0), 32'd0);

        // Randomized commands with random CPU traffic
        for (int t = 0; t < 8; t++) begin
            issue($urandom_range(0, 19), $urandom_range(0, 3), 8'($urandom));
            wait_done(2, k);
            repeat (2) step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
